// File: rtl/dm_axi_slave.sv
// -----------------------------------------------------------------------------
// dm_axi_slave
//   AXI slave wrapper for the data-memory SRAM. Accepts single and INCR/FIXED
//   bursts of 4-byte beats, one transaction at a time. Each transaction is
//   turned into SRAM cycles: active-low CEB/WEB, and read data that is
//   registered one cycle after the access. R and B responses carry the ID
//   captured at the address handshake.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   AW*/W*/B*                  AXI write address, data and response channels
//   AR*/R*                     AXI read address and data channels
//   CEB, WEB, A, DI            SRAM chip enable, byte write enables, word
//                              address and write data (all active-low enables)
//   DO                         SRAM read data (held while CEB=1)
//
// Configuration
//   DM_SLV_ADDR_CHK_EN  When defined, a transaction with non-zero address bits
//                       above the SRAM range gets SLVERR. None of its beats
//                       touch the SRAM, and its read data is zero. When
//                       undefined, the upper address bits are ignored.
// -----------------------------------------------------------------------------
module dm_axi_slave #(
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ID_W-1:0]    AWID,
  input  logic [ADDR_W-1:0]  AWADDR,
  input  logic [LEN_W-1:0]   AWLEN,
  input  logic [2:0]         AWSIZE,
  input  logic [1:0]         AWBURST,
  input  logic               AWVALID,
  output logic               AWREADY,
  input  logic [DATA_W-1:0]  WDATA,
  input  logic [3:0]         WSTRB,
  input  logic               WLAST,
  input  logic               WVALID,
  output logic               WREADY,
  output logic [ID_W-1:0]    BID,
  output logic [1:0]         BRESP,
  output logic               BVALID,
  input  logic               BREADY,
  input  logic [ID_W-1:0]    ARID,
  input  logic [ADDR_W-1:0]  ARADDR,
  input  logic [LEN_W-1:0]   ARLEN,
  input  logic [2:0]         ARSIZE,
  input  logic [1:0]         ARBURST,
  input  logic               ARVALID,
  output logic               ARREADY,
  output logic [ID_W-1:0]    RID,
  output logic [DATA_W-1:0]  RDATA,
  output logic [1:0]         RRESP,
  output logic               RLAST,
  output logic               RVALID,
  input  logic               RREADY,
  output logic               CEB,
  output logic [3:0]         WEB,
  output logic [SRAM_AW-1:0] A,
  output logic [DATA_W-1:0]  DI,
  input  logic [DATA_W-1:0]  DO
);

  // state   | meaning
  // IDLE    | waiting for AW or AR; write has priority
  // RD_ADDR | SRAM read strobe for the current beat
  // RD_DATA | RVALID with SRAM data, held until RREADY
  // WR_DATA | WREADY; each W beat is written to the SRAM in the same cycle
  // WR_RESP | BVALID held until BREADY
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_q;
  logic               incr_q;
  logic               err_q;
  logic               aw_oor, ar_oor;
  logic               beat_adv;
  logic               last_beat;

`ifdef DM_SLV_ADDR_CHK_EN
  assign aw_oor = |AWADDR[ADDR_W-1:SRAM_AW+2];
  assign ar_oor = |ARADDR[ADDR_W-1:SRAM_AW+2];
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
  logic unused_hi;
  assign unused_hi = ^{AWADDR[ADDR_W-1:SRAM_AW+2], ARADDR[ADDR_W-1:SRAM_AW+2]};
`endif

  // Beat size is fixed at 4 bytes and the burst ends on the beat count.
  // The size fields, WLAST and the byte-offset address bits are not used.
  logic unused_in;
  assign unused_in = ^{AWSIZE, ARSIZE, WLAST, AWADDR[1:0], ARADDR[1:0]};

  assign last_beat = (beat_q == len_q);
  assign beat_adv  = ((state_q == RD_DATA) && RREADY) ||
                     ((state_q == WR_DATA) && WVALID);

  assign A     = addr_q;
  assign BID   = id_q;
  assign RID   = id_q;
  assign BRESP = err_q ? 2'b10 : 2'b00;
  assign RRESP = err_q ? 2'b10 : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    AWREADY = 1'b0;
    ARREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    RDATA   = '0;
    CEB     = 1'b1;
    WEB     = 4'hF;
    DI      = '0;
    case (state_q)
      IDLE: begin
        AWREADY = 1'b1;
        ARREADY = !AWVALID;
        if (AWVALID)      state_d = WR_DATA;
        else if (ARVALID) state_d = RD_ADDR;
      end
      RD_ADDR: begin
        CEB     = err_q;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        // CEB stays high here, so DO (and therefore RDATA) holds until RREADY.
        RVALID = 1'b1;
        RLAST  = last_beat;
        RDATA  = err_q ? '0 : DO;
        if (RREADY) state_d = last_beat ? IDLE : RD_ADDR;
      end
      WR_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          CEB = err_q;
          WEB = err_q ? 4'hF : ~WSTRB;
          DI  = WDATA;
          if (last_beat) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        BVALID = 1'b1;
        if (BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
      incr_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (state_q == IDLE && AWVALID) begin
      id_q   <= AWID;
      addr_q <= AWADDR[SRAM_AW+1:2];
      len_q  <= AWLEN;
      beat_q <= '0;
      incr_q <= (AWBURST != 2'b00);   // WRAP and reserved behave as INCR
      err_q  <= aw_oor;
    end else if (state_q == IDLE && ARVALID) begin
      id_q   <= ARID;
      addr_q <= ARADDR[SRAM_AW+1:2];
      len_q  <= ARLEN;
      beat_q <= '0;
      incr_q <= (ARBURST != 2'b00);
      err_q  <= ar_oor;
    end else if (beat_adv) begin
      beat_q <= beat_q + LEN_W'(1);
      if (incr_q) addr_q <= addr_q + SRAM_AW'(1);   // wraps at SRAM depth
    end
  end

endmodule

// File: tb/tb_dm_axi_slave.sv
// -----------------------------------------------------------------------------
// tb_dm_axi_slave
//   Self-checking bench for dm_axi_slave with a behavioural SRAM attached.
//   Expected R and B responses come from a reference memory that the bench
//   keeps up to date. They are queued when a transaction is issued and
//   compared when the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_dm_axi_slave;
  localparam int DEPTH = 1 << 14;

  logic        clk, rst_n;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA, DI, DO;
  logic [3:0]  AWLEN, ARLEN, WSTRB, WEB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, CEB;
  logic [13:0] A;

  dm_axi_slave dut (
    .clk(clk), .rst_n(rst_n),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM: registered read, DO held otherwise.
  logic [31:0] sram_mem [DEPTH];
  logic [31:0] ref_mem  [DEPTH];
  logic [31:0] do_r;
  assign DO = do_r;
  always @(posedge clk) begin
    if (!CEB) begin
      for (int b = 0; b < 4; b++)
        if (!WEB[b]) sram_mem[A][8*b +: 8] <= DI[8*b +: 8];
      if (WEB == 4'hF) do_r <= sram_mem[A];
    end
  end

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;
  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t rq[$];
  b_exp_t bq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_oor(input logic [31:0] addr);
`ifdef DM_SLV_ADDR_CHK_EN
    return |addr[31:16];
`else
    return 1'b0;
`endif
  endfunction

  // Response monitor: compares every R and B handshake against the queues.
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data = '0;
  always @(negedge clk) begin
    r_exp_t re;
    b_exp_t be;
    if (rst_n && RVALID) begin
      if (hold_pend) chk("r_stable", RDATA, hold_data);
      hold_pend = !RREADY;
      hold_data = RDATA;
      if (RREADY) begin
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          re = rq.pop_front();
          chk("rid", RID, re.id);
          chk("rdata", RDATA, re.data);
          chk("rresp", RRESP, re.resp);
          chk("rlast", RLAST, re.last);
        end
      end
    end else hold_pend = 1'b0;
    if (rst_n && BVALID && BREADY) begin
      if (bq.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        be = bq.pop_front();
        chk("bid", BID, be.id);
        chk("bresp", BRESP, be.resp);
      end
    end
  end

  task automatic check_reset_outs();
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_bid", BID, 0);
    chk("rst_rid", RID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_rresp", RRESP, 0);
    chk("rst_ceb", CEB, 1);
    chk("rst_web", WEB, 4'hF);
    chk("rst_a", A, 0);
    chk("rst_di", DI, 0);
    chk("rst_awready", AWREADY, 1);
  endtask

  // Write transaction; abort_after>=0 stops after that many beats (left in WR_DATA).
  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input int abort_after, input bit with_ar);
    logic [13:0] w;
    logic        oor;
    logic [3:0]  exp_web;
    int          n;
    bit          ok;
    w   = addr[15:2];
    oor = addr_oor(addr);
    @(posedge clk); #1;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'b010; AWBURST = burst; AWVALID = 1'b1;
    if (with_ar) ARVALID = 1'b1;
    n = 0; ok = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (ARVALID) chk("ar_blocked", ARREADY, 0);
      ok = AWREADY; n++;
    end
    if (!ok) begin chk("aw_timeout", 0, 1); AWVALID = 1'b0; return; end
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == abort_after) return;
      WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == int'(len)); WVALID = 1'b1;
      @(negedge clk);
      if (ARVALID) chk("ar_blocked", ARREADY, 0);
      exp_web = oor ? 4'hF : ~ws[i];
      chk("w_ready", WREADY, 1);
      chk("w_ceb", CEB, oor);
      chk("w_web", WEB, exp_web);
      chk("w_a", A, w);
      if (!oor) begin
        chk("w_di", DI, wd[i]);
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) ref_mem[w][8*b +: 8] = wd[i][8*b +: 8];
      end
      @(posedge clk); #1;
      WVALID = 1'b0; WLAST = 1'b0;
      if (burst != 2'b00) w = w + 14'd1;
    end
    bq.push_back('{id, oor ? 2'b10 : 2'b00});
    n = 0; ok = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (ARVALID) chk("ar_blocked", ARREADY, 0);
      ok = BVALID; n++;
    end
    if (!ok) chk("b_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input bit toggle);
    logic [13:0] w, wi;
    logic        oor;
    int          n, hs_cyc;
    bit          ok, seen, done;
    w   = addr[15:2];
    wi  = w;
    oor = addr_oor(addr);
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back('{id, oor ? 32'h0 : ref_mem[wi], oor ? 2'b10 : 2'b00, i == int'(len)});
      if (burst != 2'b00) wi = wi + 14'd1;
    end
    if (!ARVALID) begin @(posedge clk); #1; end
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'b010; ARBURST = burst; ARVALID = 1'b1;
    RREADY = 1'b1;
    n = 0; ok = 0; hs_cyc = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = ARREADY; n++;
      hs_cyc = cyc;
    end
    if (!ok) begin chk("ar_timeout", 0, 1); ARVALID = 1'b0; return; end
    @(posedge clk); #1;
    ARVALID = 1'b0;
    n = 0; seen = 0; done = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("r_ceb", CEB, oor);
        if (!oor) chk("r_a", A, w);
      end
      if (RVALID && !seen) begin
        seen = 1;
        chk("r_latency", cyc - hs_cyc, 2);
      end
      if (RVALID && RREADY && RLAST) done = 1;
      @(posedge clk); #1;
      if (toggle && !done) RREADY = !RREADY;
      else RREADY = 1'b1;
    end
    if (!done) chk("r_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = 32'hC0DE_0000 | i;
      ref_mem[i]  = 32'hC0DE_0000 | i;
    end
    do_r = '0;
    rst_n = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b1;
    #12;
    check_reset_outs();
    chk("rst_arready", ARREADY, 1);
    #10 rst_n = 1'b1;

    // Single write, read back, byte-lane write, read back
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    axi_write(8'h15, 32'h0001_0010, 4'd0, 2'b01, -1, 0);
    axi_read(8'h21, 32'h0001_0010, 4'd0, 2'b01, 0);
    wd[0] = 32'h0000_AB00; ws[0] = 4'b0010;
    axi_write(8'h03, 32'h0000_0010, 4'd0, 2'b01, -1, 0);
    axi_read(8'h04, 32'h0000_0010, 4'd0, 2'b01, 0);

    // INCR burst across the top of memory with RREADY toggling
    axi_read(8'h33, (DEPTH - 2) << 2, 4'd3, 2'b01, 1);

    // INCR write burst with a zero-strobe beat, then burst read back
    wd[0] = 32'h1111_1111; ws[0] = 4'hF;
    wd[1] = 32'h2222_2222; ws[1] = 4'b1001;
    wd[2] = 32'h3333_3333; ws[2] = 4'h0;
    wd[3] = 32'h4444_4444; ws[3] = 4'hF;
    axi_write(8'h50, 32'h0000_0100, 4'd3, 2'b01, -1, 0);
    axi_read(8'h51, 32'h0000_0100, 4'd3, 2'b01, 0);

    // FIXED bursts stay on one word; WRAP behaves as INCR
    wd[0] = 32'hAAAA_0001; wd[1] = 32'hAAAA_0002; wd[2] = 32'hAAAA_0003;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
    axi_write(8'h52, 32'h0000_0200, 4'd2, 2'b00, -1, 0);
    axi_read(8'h53, 32'h0000_0200, 4'd0, 2'b01, 0);
    axi_read(8'h54, 32'h0000_0104, 4'd2, 2'b00, 1);
    axi_read(8'h55, 32'h0000_01FC, 4'd2, 2'b10, 0);

    // AW and AR together: write first, read blocked until B completes
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    ARID = 8'h66; ARADDR = 32'h0000_0400; ARLEN = 4'd0; ARSIZE = 3'b010; ARBURST = 2'b01;
    axi_write(8'h65, 32'h0000_0400, 4'd0, 2'b01, -1, 1);
    axi_read(8'h66, 32'h0000_0400, 4'd0, 2'b01, 0);

    // Reset in the middle of a 4-beat write burst
    wd[0] = 32'h5555_0000; wd[1] = 32'h5555_0001; wd[2] = 32'h5555_0002; wd[3] = 32'h5555_0003;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF; ws[3] = 4'hF;
    axi_write(8'h44, 32'h0000_0300, 4'd3, 2'b01, 2, 0);
    #3 rst_n = 1'b0;
    #1 check_reset_outs();
    rq.delete();
    bq.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    wd[0] = 32'h7777_0008; ws[0] = 4'hF;
    axi_write(8'h45, 32'h0000_0308, 4'd0, 2'b01, -1, 0);
    axi_read(8'h46, 32'h0000_0300, 4'd3, 2'b01, 0);

    // Upper address bits: SLVERR with the range check, truncated otherwise
    axi_read(8'h77, 32'h0010_0000, 4'd0, 2'b01, 0);
    wd[0] = 32'h9999_9999; ws[0] = 4'hF;
    axi_write(8'h78, 32'h0010_0008, 4'd0, 2'b01, -1, 0);
    axi_read(8'h79, 32'h0000_0008, 4'd0, 2'b01, 0);

    repeat (3) @(posedge clk);
    chk("rq_empty", rq.size(), 0);
    chk("bq_empty", bq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
